// File: rtl/spmmio_dbgbridge.sv
// rtl/spmmio_dbgbridge.sv - byte-stream host link to Wishbone initiator debug bridge
module spmmio_dbgbridge #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  rx_data,
  input  logic        rx_valid,
  output logic [0:7]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [0:23] adr_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [0:3]  sel_o,
  output logic [0:31] dat_o,
  input  logic        ack_i,
  input  logic [0:31] dat_i,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(timeout_cycles);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic        r_we;
  logic [0:3]  r_sel;
  logic [0:21] r_adr;
  logic [0:31] r_dat;
  logic        r_cyc;
  logic [15:0] r_tmo;
  logic [0:39] r_resp;
  logic [2:0]  r_resp_cnt;

  logic [0:3]  w_op;
  logic        w_op_ok;
  logic        w_tmo_reach;
  logic        w_bus_done;

  assign w_op        = rx_data[0:3];
  assign w_op_ok     = (w_op == 4'h1) || (w_op == 4'h2);
  assign w_tmo_reach = (r_tmo + 16'd1) == TMO_LIMIT;
  assign w_bus_done  = r_cyc && (ack_i || w_tmo_reach);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (rx_valid) w_state_next = w_op_ok ? S_ADDR : S_RESP;
      S_ADDR:  if (rx_valid && r_cnt == 2'd2) w_state_next = r_we ? S_WDATA : S_BUS;
      S_WDATA: if (rx_valid && r_cnt == 2'd3) w_state_next = S_BUS;
      S_BUS:   if (w_bus_done) w_state_next = S_RESP;
      S_RESP:  if (tx_ready && r_resp_cnt == 3'd1) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (r_state == S_RESP);
    busy     = (r_state != S_IDLE);
    cyc_o    = r_cyc;
    stb_o    = r_cyc;
    we_o     = r_cyc & r_we;
    tx_data  = r_resp[0:7];
    adr_o    = {r_adr, 2'b00};
    sel_o    = r_sel;
    dat_o    = r_dat;
  end

  // Datapath; r_cyc rises one cycle after BUS entry and ack beats timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_cyc      <= 1'b0;
      r_tmo      <= '0;
      r_resp     <= '0;
      r_resp_cnt <= '0;
    end else begin
      if (r_state != S_BUS) r_tmo <= '0;
      case (r_state)
        S_IDLE: if (rx_valid) begin
          if (w_op_ok) begin
            r_sel <= rx_data[4:7];
            r_we  <= (w_op == 4'h2);
            r_cnt <= '0;
          end else begin
            r_resp     <= {8'hE0, 32'h0};
            r_resp_cnt <= 3'd1;
          end
        end
        S_ADDR: if (rx_valid) begin
          case (r_cnt)
            2'd0:    r_adr[0:7]   <= rx_data;
            2'd1:    r_adr[8:15]  <= rx_data;
            default: r_adr[16:21] <= rx_data[0:5];
          endcase
          r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
        end
        S_WDATA: if (rx_valid) begin
          case (r_cnt)
            2'd0:    r_dat[0:7]   <= rx_data;
            2'd1:    r_dat[8:15]  <= rx_data;
            2'd2:    r_dat[16:23] <= rx_data;
            default: r_dat[24:31] <= rx_data;
          endcase
          r_cnt <= r_cnt + 2'd1;
        end
        S_BUS: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
          end else if (ack_i) begin
            r_cyc <= 1'b0;
            if (r_we) begin
              r_resp     <= {8'hA5, 32'h0};
              r_resp_cnt <= 3'd1;
            end else begin
              r_resp     <= {8'hA5, dat_i};
              r_resp_cnt <= 3'd5;
            end
          end else if (w_tmo_reach) begin
            r_cyc      <= 1'b0;
            r_resp     <= {8'hEE, 32'h0};
            r_resp_cnt <= 3'd1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_RESP: if (tx_ready) begin
          r_resp     <= {r_resp[8:39], 8'h00};
          r_resp_cnt <= r_resp_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spmmio_dbgbridge.sv
// tb/tb_spmmio_dbgbridge.sv - directed self-checking bench for spmmio_dbgbridge
module tb_spmmio_dbgbridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [0:7]  rx_data;
  logic        rx_valid;
  logic [0:7]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:23] adr_o;
  logic        cyc_o, stb_o, we_o;
  logic [0:3]  sel_o;
  logic [0:31] dat_o;
  logic        ack_i;
  logic [0:31] dat_i;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spmmio_dbgbridge #(.timeout_cycles(4)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .sel_o(sel_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i),
    .busy(busy)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      b = tx_data;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (stb_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic recv_read_resp(input string tag, input logic [31:0] data);
    logic [7:0] exp_b [5];
    logic [7:0] b;
    bit ok;
    exp_b[0] = 8'hA5;
    exp_b[1] = data[31:24];
    exp_b[2] = data[23:16];
    exp_b[3] = data[15:8];
    exp_b[4] = data[7:0];
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, ok);
      n_cmp++;
      if (!ok || b !== exp_b[i]) begin
        n_err++;
        $display("FAIL %s byte%0d: got %h (valid seen %0d), expected %h", tag, i, b, ok, exp_b[i]);
      end
    end
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: tx_valid=%b busy=%b, expected 0 0", tag, tx_valid, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cyc_o, stb_o, we_o, tx_valid, busy} !== 5'b0 || tx_data !== 8'h00 ||
        adr_o !== 24'h0 || sel_o !== 4'h0 || dat_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: cyc=%b stb=%b we=%b txv=%b busy=%b txd=%h adr=%h sel=%h dat=%h, expected all 0",
               cyc_o, stb_o, we_o, tx_valid, busy, tx_data, adr_o, sel_o, dat_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_write;
    logic [7:0] cmd [8];
    logic [7:0] b;
    bit ok;
    cmd = '{8'h2F, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (cmd[i]) send_byte(cmd[i]);
    n_cmp++;
    if (cyc_o !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL write_latency_n: cyc=%b busy=%b, expected 0 1", cyc_o, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1 || adr_o !== 24'h010004 || sel_o !== 4'hF ||
        we_o !== 1'b1 || dat_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_bus: cyc=%b stb=%b adr=%h sel=%h we=%b dat=%h, expected 1 1 010004 f 1 deadbeef",
               cyc_o, stb_o, adr_o, sel_o, we_o, dat_o);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (stb_o !== 1'b1) begin
      n_err++;
      $display("FAIL write_hold: stb=%b, expected 1", stb_o);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    n_cmp++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0) begin
      n_err++;
      $display("FAIL write_ack_drop: cyc=%b stb=%b we=%b, expected 0 0 0", cyc_o, stb_o, we_o);
    end
    recv_byte(b, ok);
    n_cmp++;
    if (!ok || b !== 8'hA5) begin
      n_err++;
      $display("FAIL write_resp: got %h (valid seen %0d), expected a5", b, ok);
    end
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL write_idle: tx_valid=%b busy=%b, expected 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_read;
    bit ok;
    dat_i = 32'h12345678;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    wait_stb(ok);
    n_cmp++;
    if (!ok || adr_o !== 24'h000004 || we_o !== 1'b0 || sel_o !== 4'hF) begin
      n_err++;
      $display("FAIL read_bus: stb_seen=%0d adr=%h we=%b sel=%h, expected 1 000004 0 f", ok, adr_o, we_o, sel_o);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'h0;
    recv_read_resp("read", 32'h12345678);
  endtask

  task automatic test_timeout;
    int hi = 0;
    logic [7:0] b;
    bit ok;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_o) hi++;
    end
    n_cmp++;
    if (hi != 4) begin
      n_err++;
      $display("FAIL timeout_stb_cycles: got %0d, expected 4", hi);
    end
    recv_byte(b, ok);
    n_cmp++;
    if (!ok || b !== 8'hEE) begin
      n_err++;
      $display("FAIL timeout_resp: got %h (valid seen %0d), expected ee", b, ok);
    end
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: busy=%b tx_valid=%b, expected 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_ack_vs_timeout;
    bit ok;
    dat_i = 32'hCAFEF00D;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    wait_stb(ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || stb_o !== 1'b1) begin
      n_err++;
      $display("FAIL race_stb_fourth: stb=%b seen=%0d, expected 1", stb_o, ok);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'h0;
    recv_read_resp("ack_vs_timeout", 32'hCAFEF00D);
  endtask

  task automatic test_bad_opcode;
    int bad = 0;
    logic [7:0] b;
    bit ok;
    send_byte(8'h7F);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hE0 || cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL badop_first: txv=%b txd=%h cyc=%b, expected 1 e0 0", tx_valid, tx_data, cyc_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hE0 || cyc_o !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL badop_stall: %0d unstable cycles, expected 0", bad);
    end
    recv_byte(b, ok);
    n_cmp++;
    if (!ok || b !== 8'hE0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL badop_resp: got %h busy=%b, expected e0 0", b, busy);
    end
  endtask

  task automatic test_reset_mid_bus;
    int seen = 0;
    bit ok;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    wait_stb(ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!ok || cyc_o !== 1'b0 || stb_o !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_bus_drop: cyc=%b stb=%b txv=%b busy=%b, expected 0 0 0 0", cyc_o, stb_o, tx_valid, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_bus_no_resp: tx_valid high %0d cycles, expected 0", seen);
    end
    dat_i = 32'h0BADF00D;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    wait_stb(ok);
    n_cmp++;
    if (!ok || adr_o !== 24'h000100) begin
      n_err++;
      $display("FAIL rst_then_read_adr: adr=%h seen=%0d, expected 000100", adr_o, ok);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'h0;
    recv_read_resp("after_reset", 32'h0BADF00D);
  endtask

  task automatic test_ignore_injected;
    logic [7:0] b;
    bit ok;
    ack_i = 1'b1;
    repeat (3) @(negedge clk);
    ack_i = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || cyc_o !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack_ignored: busy=%b cyc=%b txv=%b, expected 0 0 0", busy, cyc_o, tx_valid);
    end
    send_byte(8'h2F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_stb(ok);
    rx_data  = 8'h7F;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    n_cmp++;
    if (!ok || stb_o !== 1'b1 || adr_o !== 24'h000010 || dat_o !== 32'h11223344) begin
      n_err++;
      $display("FAIL bus_rx_ignored: stb=%b adr=%h dat=%h, expected 1 000010 11223344", stb_o, adr_o, dat_o);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    rx_data  = 8'h1F;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    recv_byte(b, ok);
    n_cmp++;
    if (!ok || b !== 8'hA5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL resp_rx_ignored: got %h busy=%b, expected a5 0", b, busy);
    end
    dat_i = 32'h55AA0FF0;
    send_byte(8'h1F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    wait_stb(ok);
    n_cmp++;
    if (!ok || adr_o !== 24'h000020 || we_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_inject_decode: adr=%h we=%b seen=%0d, expected 000020 0", adr_o, we_o, ok);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'h0;
    recv_read_resp("post_inject", 32'h55AA0FF0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    ack_i    = 1'b0;
    dat_i    = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_vs_timeout();
    test_bad_opcode();
    test_reset_mid_bus();
    test_ignore_injected();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spmmio_dbgbridge.md
SPMMIO_DBGBRIDGE -- requirements
Module: spmmio_dbgbridge

Interface
REQ-001 SHALL have parameter: timeout_cycles, default 255, cycles a bus cycle waits for ack_i before abort (range 1..65535).
REQ-002 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx_data  input  [0:7]  command byte from host link (bit 0 = MSB).
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe qualifying rx_data; no backpressure.
REQ-006 SHALL have port: tx_data  output  [0:7]  response byte to host link.
REQ-007 SHALL have port: tx_valid  output  1  tx_data valid; held until accepted.
REQ-008 SHALL have port: tx_ready  input  1  link accepts tx_data when tx_valid and tx_ready both high at an edge.
REQ-009 SHALL have Wishbone initiator ports: adr_o output [0:23], cyc_o output 1, stb_o output 1, we_o output 1, sel_o output [0:3], dat_o output [0:31], ack_i input 1, dat_i input [0:31]; all bit 0 = MSB, adr_o bit 21 least significant used.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, ADDR, WDATA, BUS, RESP.
REQ-012 IDLE: on rx_valid, byte = {op[0:3], sel[0:3]}; op 4'h1 = read, 4'h2 = write; latch sel, go ADDR with byte counter 0.
REQ-013 IDLE: op other than 1/2 SHALL load response 8'hE0 (one byte) and go RESP.
REQ-014 ADDR: three rx_valid bytes SHALL fill adr[0:7], adr[8:15], adr[16:23] in order; after third, read goes BUS, write goes WDATA.
REQ-015 WDATA: four rx_valid bytes SHALL fill dat[0:7] .. dat[24:31] in order, then go BUS.
REQ-016 adr_o SHALL present the received address with bits 22:23 forced to 0.
REQ-017 BUS: cyc_o and stb_o SHALL assert the cycle after entering BUS and hold with adr_o, sel_o, we_o (1 for write), dat_o stable until ack_i or timeout.
REQ-018 cyc_o/stb_o SHALL deassert on the edge where ack_i is sampled high; read SHALL capture dat_i on that same edge.
REQ-019 Timeout counter (16 bit) SHALL clear on BUS entry, increment each BUS cycle without ack_i; reaching timeout_cycles SHALL drop cyc_o/stb_o and load response 8'hEE (one byte).
REQ-020 ack_i and timeout in the same cycle: ack SHALL win.
REQ-021 Successful write SHALL load response 8'hA5 (one byte); successful read SHALL load 8'hA5 followed by captured data bytes [0:7], [8:15], [16:23], [24:31] (five bytes).
REQ-022 RESP: tx_valid high with current byte; advance only on tx_valid && tx_ready; after last byte accepted, tx_valid low next cycle and state IDLE.
REQ-023 tx_data SHALL not change while tx_valid high and tx_ready low.
REQ-024 rx_valid during BUS and RESP SHALL be ignored (byte dropped, no state effect).
REQ-025 Outside BUS, cyc_o, stb_o, we_o SHALL be 0; dat_o/adr_o/sel_o hold last values.
REQ-026 ack_i sampled outside BUS SHALL be ignored.
REQ-027 Latency: third address byte (read) or fourth data byte (write) at edge N -> cyc_o/stb_o high after edge N+1.

Reset
REQ-028 On reset: state IDLE, cyc_o=0, stb_o=0, we_o=0, tx_valid=0, busy=0, tx_data=0, adr_o=0, sel_o=0, dat_o=0, counters 0.
REQ-029 Reset mid-BUS SHALL drop cyc_o/stb_o at that edge without response; reset mid-RESP SHALL discard remaining bytes.

Verification
REQ-030 Write: rx 8'h2F,8'h01,8'h00,8'h04,DE,AD,BE,EF -> one cycle adr_o=24'h010004, sel_o=4'hF, we_o=1, dat_o=32'hDEADBEEF; ack after 3 cycles -> tx 8'hA5.
REQ-031 Read: rx 8'h1F,8'h00,8'h00,8'h07 with dat_i=32'h12345678 at ack -> adr_o=24'h000004, we_o=0; tx A5,12,34,56,78.
REQ-032 Timeout: timeout_cycles=4, read with ack_i never high -> stb_o high exactly 4 cycles, then tx 8'hEE, busy low after accept.
REQ-033 Bad opcode 8'h7F -> no bus cycle, tx 8'hE0; tx_ready held low 10 cycles -> tx_data stable 8'hE0 throughout.
REQ-034 Reset asserted 2 cycles into BUS -> cyc_o=0 next edge, no tx_valid; following read command completes normally.
REQ-035 rx bytes injected during BUS/RESP -> ignored; subsequent command decodes correctly from IDLE.
